pio_out_pulse: RTL and testbench

PIO_OUT_PULSE -- requirements
Module: pio_out_pulse

---
 rtl/pio_out_pulse_pkg.sv | 14 +
 rtl/pio_pulse_timer.sv | 43 ++++
 rtl/pio_out_pulse.sv | 135 +++++++++++++
 tb/tb_pio_out_pulse.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_out_pulse_pkg.sv
// Shared register map for pio_out_pulse: word addresses and STATUS bit positions.
package pio_out_pulse_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE = 3'd3;
    localparam logic [2:0] ADDR_PLEN   = 3'd4;
    localparam logic [2:0] ADDR_PULSE  = 3'd5;
    localparam logic [2:0] ADDR_STATUS = 3'd6;

    localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/pio_pulse_timer.sv
// Pulse length counter: loads max(len,1), counts down while active, flags the expiry cycle.
module pio_pulse_timer
    import pio_out_pulse_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] len,
    input  logic             active,
    output logic             expire
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load_val;

    // A zero length still produces a one-cycle pulse.
    always_comb begin
        if (len == '0) begin
            w_load_val = CNT_W'(1'b1);
        end else begin
            w_load_val = len;
        end
    end

    // A reload in the same cycle wins over expiry so pending bits are extended.
    assign expire = active & ~load & (r_cnt == CNT_W'(1'b1));

    // Down counter, reloaded on every accepted pulse request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= w_load_val;
        end else if (active && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1'b1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/pio_out_pulse.sv
// Avalon-MM output port with DATA/SET/CLEAR/TOGGLE registers and optional timed pulses.
// The pulse engine (PLEN, PULSE, STATUS) is built only when PIO_OUT_PULSE_EN is defined.
module pio_out_pulse
    import pio_out_pulse_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             pulse_busy
);

    logic             w_wr;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_data_wr;
    logic [WIDTH-1:0] w_data_nxt;
    logic [WIDTH-1:0] r_data;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_mask         = writedata[WIDTH-1:0];
    assign w_unused_wdata = &{1'b0, writedata};
    assign out_port       = r_data;

    // DATA as the plain register-map write would leave it.
    always_comb begin
        w_data_wr = r_data;
        if (w_wr) begin
            case (address)
                ADDR_DATA:   w_data_wr = w_mask;
                ADDR_SET:    w_data_wr = r_data | w_mask;
                ADDR_CLEAR:  w_data_wr = r_data & ~w_mask;
                ADDR_TOGGLE: w_data_wr = r_data ^ w_mask;
                default:     w_data_wr = r_data;
            endcase
        end else begin
            w_data_wr = r_data;
        end
    end

`ifdef PIO_OUT_PULSE_EN
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_pend_nxt;
    logic [CNT_W-1:0] r_plen;
    logic             r_busy;
    logic             w_pulse_wr;
    logic             w_active;
    logic             w_expire;

    assign w_pulse_wr = w_wr & (address == ADDR_PULSE) & (w_mask != '0);
    assign w_active   = (r_pend != '0);
    assign pulse_busy = r_busy;

    pio_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (w_pulse_wr),
        .len    (r_plen),
        .active (w_active),
        .expire (w_expire)
    );

    // Expiry clears pending bits even against a same-cycle write; writes that zero a pending bit drop it.
    always_comb begin
        w_data_nxt = w_data_wr;
        w_pend_nxt = r_pend;
        if (w_expire) begin
            w_data_nxt = w_data_wr & ~r_pend;
            w_pend_nxt = '0;
        end else if (w_pulse_wr) begin
            w_data_nxt = r_data | w_mask;
            w_pend_nxt = r_pend | w_mask;
        end else begin
            w_data_nxt = w_data_wr;
            w_pend_nxt = r_pend & w_data_wr;
        end
    end

    // Pulse engine state and the registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
            r_plen <= '0;
            r_busy <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_busy <= (w_pend_nxt != '0);
            if (w_wr && (address == ADDR_PLEN)) begin
                r_plen <= writedata[CNT_W-1:0];
            end else begin
                r_plen <= r_plen;
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;

    assign w_data_nxt = w_data_wr;
    assign pulse_busy = 1'b0;
`endif

    // Output data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= RESET_VALUE;
        end else begin
            r_data <= w_data_nxt;
        end
    end

    // Combinational, zero-extended read mux.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:   readdata[WIDTH-1:0] = r_data;
`ifdef PIO_OUT_PULSE_EN
            ADDR_PLEN:   readdata[CNT_W-1:0] = r_plen;
            ADDR_PULSE:  readdata[WIDTH-1:0] = r_pend;
            ADDR_STATUS: readdata[STATUS_BUSY_BIT] = r_busy;
`endif
            default:     readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pio_out_pulse.sv
// Randomized and directed bench for pio_out_pulse against a deadline-based reference model.
module tb_pio_out_pulse;

    localparam logic [7:0] RV = 8'h3C;
`ifdef PIO_OUT_PULSE_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        pulse_busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: pending bits expire at an absolute edge number.
    logic [7:0]  m_data;
    logic [7:0]  m_pend;
    logic [15:0] m_plen;
    int          m_deadline = 0;
    int          n_edge = 0;

    pio_out_pulse #(
        .WIDTH       (8),
        .RESET_VALUE (RV),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_busy (pulse_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, n_edge);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd4:    return EN ? {16'd0, m_plen} : 32'd0;
            3'd5:    return EN ? {24'd0, m_pend} : 32'd0;
            3'd6:    return EN ? {31'd0, (m_pend != 8'd0)} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_edge(input bit rst, input bit cs, input bit wn,
                                   input logic [2:0] a, input logic [31:0] wd);
        bit         wr;
        bit         pulse;
        bit         expire;
        logic [7:0] mask;
        logic [7:0] nd;
        if (rst) begin
            m_data = RV;
            m_pend = 8'd0;
            m_plen = 16'd0;
            return;
        end
        wr     = cs && !wn;
        mask   = wd[7:0];
        pulse  = EN && wr && (a == 3'd5) && (mask != 8'd0);
        expire = EN && (m_pend != 8'd0) && (n_edge == m_deadline) && !pulse;
        nd = m_data;
        if (wr) begin
            case (a)
                3'd0:    nd = mask;
                3'd1:    nd = m_data | mask;
                3'd2:    nd = m_data & ~mask;
                3'd3:    nd = m_data ^ mask;
                default: nd = m_data;
            endcase
        end
        if (pulse) begin
            m_data     = m_data | mask;
            m_pend     = m_pend | mask;
            m_deadline = n_edge + ((m_plen == 16'd0) ? 1 : int'(m_plen));
        end else if (expire) begin
            m_data = nd & ~m_pend;
            m_pend = 8'd0;
        end else begin
            m_data = nd;
            m_pend = m_pend & nd;
        end
        if (EN && wr && (a == 3'd4)) m_plen = wd[15:0];
    endfunction

    // One clock: drive, compare against the model, advance model, return just after the edge.
    task automatic cyc(input bit rst, input bit cs, input bit wn,
                       input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd;
        #1;
        chk("out_port", {24'd0, out_port}, {24'd0, m_data});
        chk("pulse_busy", {31'd0, pulse_busy}, {31'd0, (m_pend != 8'd0)});
        chk("readdata", readdata, m_read(a));
        n_edge++;
        m_edge(rst, cs, wn, a, wd);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        cyc(1'b0, 1'b1, 1'b0, a, wd);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    initial begin
        int cnt0;
        int cnt1;
        logic [2:0]  ra;
        logic [31:0] rd;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        m_edge(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("reset_out", {24'd0, out_port}, 32'h3C);
        chk("reset_busy", {31'd0, pulse_busy}, 32'd0);

        // Register-map arithmetic with literal expectations.
        wr(3'd0, 32'hA5); chk("data_a5", {24'd0, out_port}, 32'hA5);
        wr(3'd1, 32'h0F); chk("set_0f", {24'd0, out_port}, 32'hAF);
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 32'd0); chk("rd_set", readdata, 32'd0);
        wr(3'd2, 32'h81); chk("clear_81", {24'd0, out_port}, 32'h2E);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 32'd0); chk("rd_clear", readdata, 32'd0);
        wr(3'd3, 32'hFF); chk("toggle_ff", {24'd0, out_port}, 32'hD1);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 32'd0); chk("rd_toggle", readdata, 32'd0);

`ifdef PIO_OUT_PULSE_EN
        // PLEN=5 pulse of 0x03 lasts exactly five cycles.
        wr(3'd0, 32'h00); wr(3'd4, 32'd5); wr(3'd5, 32'h03);
        cnt0 = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_port == 8'h03 && pulse_busy) cnt0++;
            idle();
        end
        chk("plen5_cycles", cnt0, 5);
        chk("plen5_after", {23'd0, pulse_busy, out_port}, 32'h000);

        // PLEN=0 behaves as a single-cycle pulse.
        wr(3'd4, 32'd0); wr(3'd5, 32'h80);
        cnt0 = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_port[7]) cnt0++;
            idle();
        end
        chk("plen0_cycles", cnt0, 1);

        // Retrigger extends earlier bits to the shared new expiry.
        wr(3'd4, 32'd10); wr(3'd5, 32'h01);
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 24; i++) begin
            if (out_port[0]) cnt0++;
            if (out_port[1]) cnt1++;
            if (i == 3) wr(3'd5, 32'h02);
            else idle();
        end
        chk("retrig_bit0", cnt0, 14);
        chk("retrig_bit1", cnt1, 10);

        // SET on the expiry edge loses to expiry.
        wr(3'd4, 32'd3); wr(3'd5, 32'h01); idle(); idle(); wr(3'd1, 32'h01);
        chk("set_at_expiry", {23'd0, pulse_busy, out_port}, 32'h000);

        // Reset in the middle of a pulse.
        wr(3'd4, 32'd6); wr(3'd5, 32'h0F); idle();
        chk("pulse_active", {23'd0, pulse_busy, out_port}, 32'h10F);
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
        chk("reset_mid_pulse", {23'd0, pulse_busy, out_port}, 32'h03C);
`else
        // Pulse register is inert without the engine.
        wr(3'd0, 32'h5A); wr(3'd5, 32'hFF);
        chk("nopulse_out", {24'd0, out_port}, 32'h5A);
        cyc(1'b0, 1'b0, 1'b1, 3'd5, 32'd0);
        chk("nopulse_rd5", readdata, 32'd0);
        chk("nopulse_busy", {31'd0, pulse_busy}, 32'd0);
`endif

        // Random traffic, biased toward pulse activity.
        for (int i = 0; i < 600; i++) begin
            ra = 3'($urandom_range(0, 9) > 7 ? 5 : $urandom_range(0, 7));
            rd = $urandom;
            if (ra == 3'd4) rd = 32'($urandom_range(0, 12));
            if (ra == 3'd5 && $urandom_range(0, 5) == 0) rd = 32'd0;
            cyc(($urandom_range(0, 79) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0, ra, rd);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
